// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch slice.
//   XLEN             - datapath / address width
//   PC_INC           - sequential fetch stride in bytes
//   DEFAULT_RESET_PC - default first fetch address after reset
//   state_t          - fetch controller state encoding
//   word_align()     - clears the byte-offset bits of an address
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;

    // ST_FETCH: request issued or outstanding
    // ST_HOLD : prefetch buffer full, no request
    // ST_DROP : one stale response still owed by memory, discard it
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: bundles the instruction-memory bus, the execute redirect,
// and the decode-side instruction handoff of the fetch unit.
//   master modport: the fetch unit (drives mem_adr/mem_req/mem_load, if_*,
//                   fetch_fault, fetch_state debug view)
//   slave modport : memory + execute + decode side
// Handshakes:
//   memory - mem_req/mem_adr held stable until mem_done; mem_done may arrive
//            in the request cycle itself or any later cycle.
//   decode - an instruction transfers on a cycle where if_valid && id_ready.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] mem_adr;
    logic            mem_req;
    logic            mem_load;
    logic [XLEN-1:0] mem_data;
    logic            mem_done;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            id_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            fetch_fault;
    state_t          fetch_state;

    modport master (
        output mem_adr, mem_req, mem_load, if_valid, if_instr, if_pc,
               fetch_fault, fetch_state,
        input  mem_data, mem_done, br_taken, br_target, id_ready
    );

    modport slave (
        input  mem_adr, mem_req, mem_load, if_valid, if_instr, if_pc,
               fetch_fault, fetch_state,
        output mem_data, mem_done, br_taken, br_target, id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO used as the prefetch buffer.
//   clk, rst  - clock, synchronous active-high reset
//   push, din - write an entry (accepted when not full, or full with pop)
//   pop, dout - remove the head entry; dout shows the head combinationally
//   flush     - empty the FIFO (dominates push and pop)
//   full, empty, count - occupancy status
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit with a small prefetch buffer.
//   clk, rst - clock, synchronous active-high reset
//   bus      - instr_fetch_if.master (memory bus, redirect, decode handoff,
//              fetch_fault, fetch_state debug view)
// Parameters: RESET_PC (first fetch address), FIFO_DEPTH (2..8, power of two).
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target sets
// the sticky fetch_fault and halts fetching until reset. Without it the
// target's low two bits are ignored and fetch_fault is always 0.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    instr_fetch_if.master  bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   tgt;
    logic              fault_q;
    logic              misaligned;
    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic              full_unused;
    logic [CW-1:0]     fifo_count;
    logic [2*XLEN-1:0] head;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = bus.br_taken && (bus.br_target[1:0] != 2'b00);
    assign tgt        = bus.br_target;

    always_ff @(posedge clk) begin
        if (rst)             fault_q <= 1'b0;
        else if (misaligned) fault_q <= 1'b1;
    end
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = |bus.br_target[1:0];
    assign misaligned     = 1'b0;
    assign fault_q        = 1'b0;
    assign tgt            = word_align(bus.br_target);
`endif

    assign bus.mem_req     = !rst && (state == ST_FETCH) && !fault_q;
    assign bus.mem_adr     = pc;
    assign bus.mem_load    = 1'b0;
    assign bus.fetch_fault = fault_q;
    assign bus.fetch_state = state;

    assign bus.if_valid = !rst && !fifo_empty;
    assign bus.if_pc    = bus.if_valid ? head[2*XLEN-1:XLEN] : '0;
    assign bus.if_instr = bus.if_valid ? head[XLEN-1:0]      : '0;

    // A redirect wins over both the arriving response and the decode pop.
    assign accept = bus.mem_req && bus.mem_done;
    assign push   = accept && !bus.br_taken;
    assign pop    = bus.if_valid && bus.id_ready && !bus.br_taken;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.br_taken),
        .din   ({pc, bus.mem_data}),
        .dout  (head),
        .full  (full_unused),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (bus.br_taken && !misaligned) pc <= tgt;
            else if (push)                   pc <= pc + PC_INC;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (bus.br_taken) begin
                    // Request still owed by memory: its answer must be thrown away.
                    if (bus.mem_req && !bus.mem_done) state_nxt = ST_DROP;
                end else if (push && !pop &&
                             fifo_count == CW'(FIFO_DEPTH - 1)) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.br_taken || pop) state_nxt = ST_FETCH;
            end
            ST_DROP: begin
                if (bus.mem_done) state_nxt = ST_FETCH;
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: memory model with selectable latency,
// second instance with a wrapping RESET_PC.
module tb_instr_fetch;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus_w ();

  instr_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w.master)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // memory model: lat == 0 answers in the request cycle, else lat cycles later
  int          lat;
  logic        busy;
  int          cnt;
  logic [31:0] lat_adr;

  always_comb begin
    if (lat == 0) begin
      bus.mem_done = bus.mem_req;
      bus.mem_data = word_of(bus.mem_adr);
    end else begin
      bus.mem_done = busy && (cnt == 0);
      bus.mem_data = bus.mem_done ? word_of(lat_adr) : 32'h0;
    end
  end

  always @(posedge clk) begin
    if (rst || lat == 0) begin
      busy <= 1'b0;
      cnt  <= 0;
    end else if (bus.mem_done) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1;
    end else if (bus.mem_req) begin
      busy    <= 1'b1;
      cnt     <= lat - 1;
      lat_adr <= bus.mem_adr;
    end
  end

  // wrap instance: zero-latency memory, decode always ready
  assign bus_w.mem_done  = bus_w.mem_req;
  assign bus_w.mem_data  = word_of(bus_w.mem_adr);
  assign bus_w.br_taken  = 1'b0;
  assign bus_w.br_target = 32'h0;
  assign bus_w.id_ready  = 1'b1;

  // driver tasks
  task automatic do_reset(input int l, input logic rdy);
    rst = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = 32'h0;
    bus.id_ready = rdy;
    lat = l;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.br_taken = 1'b0;
    bus.br_target = 32'h0;
    bus.id_ready = 1'b1;
    lat = 0;
    repeat (2) @(negedge clk);
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b exp 0", bus.mem_req); else passed++;
    checks++; if (bus.if_valid !== 1'b0) $display("FAIL rst_if_valid: got %b exp 0", bus.if_valid); else passed++;
    checks++; if (bus.if_instr !== 32'h0) $display("FAIL rst_if_instr: got %h exp 0", bus.if_instr); else passed++;
    checks++; if (bus.if_pc !== 32'h0) $display("FAIL rst_if_pc: got %h exp 0", bus.if_pc); else passed++;
    checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL rst_fault: got %b exp 0", bus.fetch_fault); else passed++;
    checks++; if (bus.mem_adr !== 32'h0) $display("FAIL rst_mem_adr: got %h exp 0", bus.mem_adr); else passed++;
    checks++; if (bus.mem_load !== 1'b0) $display("FAIL rst_mem_load: got %b exp 0", bus.mem_load); else passed++;
    checks++; if (bus.fetch_state !== ST_FETCH) $display("FAIL rst_state: got %0d exp %0d", bus.fetch_state, ST_FETCH); else passed++;
    checks++; if (bus_w.mem_adr !== 32'hFFFF_FFF8) $display("FAIL rst_w_mem_adr: got %h exp fffffff8", bus_w.mem_adr); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset(0, 1'b1);
    #1;
    checks++; if (bus.mem_req !== 1'b1) $display("FAIL seq_req_rise: got %b exp 1", bus.mem_req); else passed++;
    checks++; if (bus.if_valid !== 1'b0) $display("FAIL seq_no_valid_yet: got %b exp 0", bus.if_valid); else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_pc = 32'(i * 4);
      checks++; if (bus.if_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b exp 1", i, bus.if_valid); else passed++;
      checks++; if (bus.if_pc !== exp_pc) $display("FAIL seq_pc[%0d]: got %h exp %h", i, bus.if_pc, exp_pc); else passed++;
      checks++; if (bus.if_instr !== word_of(exp_pc)) $display("FAIL seq_instr[%0d]: got %h exp %h", i, bus.if_instr, word_of(exp_pc)); else passed++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hFFFF_FFF8;
    exp_w[1] = 32'hFFFF_FFFC;
    exp_w[2] = 32'h0000_0000;
    do_reset(0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_w.if_valid !== 1'b1) $display("FAIL wrap_valid[%0d]: got %b exp 1", i, bus_w.if_valid); else passed++;
      checks++; if (bus_w.if_pc !== exp_w[i]) $display("FAIL wrap_pc[%0d]: got %h exp %h", i, bus_w.if_pc, exp_w[i]); else passed++;
    end
  endtask

  task automatic test_hold();
    do_reset(0, 1'b0);
    repeat (5) @(negedge clk);
    checks++; if (bus.fetch_state !== ST_HOLD) $display("FAIL hold_state: got %0d exp %0d", bus.fetch_state, ST_HOLD); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL hold_req: got %b exp 0", bus.mem_req); else passed++;
    checks++; if (bus.mem_adr !== 32'h8) $display("FAIL hold_adr: got %h exp 8", bus.mem_adr); else passed++;
    checks++; if (bus.if_pc !== 32'h0) $display("FAIL hold_head: got %h exp 0", bus.if_pc); else passed++;
    bus.id_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.fetch_state !== ST_FETCH) $display("FAIL hold_release_state: got %0d exp %0d", bus.fetch_state, ST_FETCH); else passed++;
    checks++; if (bus.if_pc !== 32'h4) $display("FAIL hold_second: got %h exp 4", bus.if_pc); else passed++;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_adr !== 32'h8) $display("FAIL hold_refetch: got req=%b adr=%h exp req=1 adr=8", bus.mem_req, bus.mem_adr); else passed++;
    @(negedge clk);
    checks++; if (bus.if_pc !== 32'h8) $display("FAIL hold_third: got %h exp 8", bus.if_pc); else passed++;
  endtask

  task automatic test_drop_latency();
    int n;
    do_reset(3, 1'b1);
    @(negedge clk);
    bus.br_taken = 1'b1;
    bus.br_target = 32'h100;
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
    checks++; if (bus.fetch_state !== ST_DROP) $display("FAIL drop_state: got %0d exp %0d", bus.fetch_state, ST_DROP); else passed++;
    checks++; if (bus.mem_req !== 1'b0) $display("FAIL drop_req: got %b exp 0", bus.mem_req); else passed++;
    checks++; if (bus.mem_adr !== 32'h100) $display("FAIL drop_adr: got %h exp 100", bus.mem_adr); else passed++;
    n = 0;
    while (bus.if_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.if_valid !== 1'b1) $display("FAIL drop_timeout: got if_valid=%b exp 1 within 20 cycles", bus.if_valid); else passed++;
    checks++; if (bus.if_pc !== 32'h100) $display("FAIL drop_pc: got %h exp 100", bus.if_pc); else passed++;
    checks++; if (bus.if_instr !== word_of(32'h100)) $display("FAIL drop_instr: got %h exp %h", bus.if_instr, word_of(32'h100)); else passed++;
  endtask

  task automatic test_branch_done();
    do_reset(0, 1'b1);
    repeat (2) @(negedge clk);
    // head is pc 4, pop and a zero-latency response both pending this cycle
    bus.br_taken = 1'b1;
    bus.br_target = 32'h40;
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
    checks++; if (bus.if_valid !== 1'b0) $display("FAIL br_flush_valid: got %b exp 0", bus.if_valid); else passed++;
    checks++; if (bus.mem_adr !== 32'h40) $display("FAIL br_adr: got %h exp 40", bus.mem_adr); else passed++;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40) $display("FAIL br_first: got valid=%b pc=%h exp valid=1 pc=40", bus.if_valid, bus.if_pc); else passed++;
    @(negedge clk);
    checks++; if (bus.if_pc !== 32'h44) $display("FAIL br_second: got %h exp 44", bus.if_pc); else passed++;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(1, 1'b1);
    @(negedge clk);
    // the response is on the bus this cycle; reset must keep it out
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL rmid_held: got valid=%b req=%b exp 0 0", bus.if_valid, bus.mem_req); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (bus.mem_req !== 1'b1 || bus.mem_adr !== 32'h0) $display("FAIL rmid_restart: got req=%b adr=%h exp 1 0", bus.mem_req, bus.mem_adr); else passed++;
    n = 0;
    while (bus.if_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) $display("FAIL rmid_first: got valid=%b pc=%h exp 1 0", bus.if_valid, bus.if_pc); else passed++;
  endtask

  task automatic test_align();
    do_reset(0, 1'b1);
    @(negedge clk);
    bus.br_taken = 1'b1;
    bus.br_target = 32'h102;
    @(negedge clk);
    bus.br_taken = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (bus.fetch_fault !== 1'b1) $display("FAIL align_fault: got %b exp 1", bus.fetch_fault); else passed++;
    checks++; if (bus.mem_req !== 1'b0 || bus.if_valid !== 1'b0) $display("FAIL align_stop: got req=%b valid=%b exp 0 0", bus.mem_req, bus.if_valid); else passed++;
    repeat (4) @(negedge clk);
    checks++; if (bus.fetch_fault !== 1'b1 || bus.mem_req !== 1'b0) $display("FAIL align_sticky: got fault=%b req=%b exp 1 0", bus.fetch_fault, bus.mem_req); else passed++;
    do_reset(0, 1'b1);
    #1;
    checks++; if (bus.fetch_fault !== 1'b0 || bus.mem_req !== 1'b1) $display("FAIL align_clear: got fault=%b req=%b exp 0 1", bus.fetch_fault, bus.mem_req); else passed++;
`else
    checks++; if (bus.fetch_fault !== 1'b0) $display("FAIL align_fault: got %b exp 0", bus.fetch_fault); else passed++;
    checks++; if (bus.mem_adr !== 32'h100) $display("FAIL align_force: got %h exp 100", bus.mem_adr); else passed++;
    @(negedge clk);
    checks++; if (bus.if_pc !== 32'h100) $display("FAIL align_pc: got %h exp 100", bus.if_pc); else passed++;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_sequential();
    test_wrap();
    test_hold();
    test_drop_latency();
    test_branch_done();
    test_reset_mid();
    test_align();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
